// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared state encoding, flag bit positions and entry width for the commit trace buffer
package cpu_trace_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;
    localparam int FLG_MEMREAD  = 4;
    localparam int FLG_MEMWRITE = 3;
    localparam int FLG_REGWRITE = 2;
    localparam int FLG_BRANCH   = 1;
    localparam int FLG_ZERO     = 0;
    function automatic int entry_w(input int xlen);
        return 2 * xlen + 37;
    endfunction
endpackage

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: commit tap, control and drain port of the trace buffer
interface cpu_trace_buffer_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CYC_W = 16
);
    import cpu_trace_pkg::*;
    localparam int EW = entry_w(XLEN);
    localparam int CW = $clog2(DEPTH + 1);
    logic            arm;
    logic            stop;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic [31:0]     commit_instr;
    logic [XLEN-1:0] commit_alu;
    logic [4:0]      commit_flags;
    logic            trig_en;
    logic [XLEN-1:0] trig_pc;
    logic            rd_en;
    logic [EW-1:0]   rd_data;
    logic            rd_valid;
    logic [CW-1:0]   count;
    logic [1:0]      state;
    logic            halted;
    logic            timeout;
    logic            overflow;
    logic [CYC_W-1:0] cycle_count;
    modport master (
        output arm, stop, commit_valid, commit_pc, commit_instr, commit_alu, commit_flags,
               trig_en, trig_pc, rd_en,
        input  rd_data, rd_valid, count, state, halted, timeout, overflow, cycle_count
    );
    modport slave (
        input  arm, stop, commit_valid, commit_pc, commit_instr, commit_alu, commit_flags,
               trig_en, trig_pc, rd_en,
        output rd_data, rd_valid, count, state, halted, timeout, overflow, cycle_count
    );
endinterface

// File: rtl/trace_ring_mem.sv
// trace_ring_mem: circular entry store with registered pop port and optional overwrite-oldest on full
module trace_ring_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 101,
    parameter int WRAP  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_clr,
    input  logic                         i_wr,
    input  logic [W-1:0]                 i_wr_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_rd_data,
    output logic                         o_rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rd_data;
    logic          r_rd_valid;
    logic          w_full, w_pop, w_push;
    assign w_full = r_cnt == CW'(DEPTH);
    assign w_pop  = i_pop && r_cnt != '0 && !i_clr;
    assign w_push = i_wr && !i_clr && (!w_full || w_pop || WRAP != 0);
    // a full push with no pop evicts the oldest entry
    assign o_ovf  = w_push && w_full && !w_pop;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_wr_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) r_rd_data <= r_mem[r_rp];
            r_wp  <= i_clr ? '0 : r_wp + AW'(w_push);
            r_rp  <= i_clr ? '0 : r_rp + AW'(w_pop || o_ovf);
            r_cnt <= i_clr ? '0 : r_cnt + CW'(w_push && !o_ovf) - CW'(w_pop);
        end
    end
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_count    = r_cnt;
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: commit-trace capture with PC trigger, halt-loop detection and cycle watchdog
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int WRAP_MODE   = 0,
    parameter int HALT_REPEAT = 4,
    parameter int MAX_CYCLES  = 100,
    parameter int CYC_W       = 16
) (
    input logic               clk,
    input logic               reset,
    cpu_trace_buffer_if.slave bus
);
    localparam int EW = entry_w(XLEN);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(HALT_REPEAT + 1);
    state_t           r_state, w_next;
    logic             r_halted, r_timeout, r_overflow;
    logic [CYC_W-1:0] r_cycle;
    logic [XLEN-1:0]  r_last_pc;
    logic [RW-1:0]    r_rep, w_rep_n;
    logic             w_run, w_wr, w_pop, w_to, w_halt, w_fill, w_ovf;
    logic [CW-1:0]    w_count;
    logic [EW-1:0]    w_entry, w_rd_data;
    logic             w_rd_valid;
    logic [4:0]       w_flags;
    assign w_flags = {bus.commit_flags[FLG_MEMREAD], bus.commit_flags[FLG_MEMWRITE],
                      bus.commit_flags[FLG_REGWRITE], bus.commit_flags[FLG_BRANCH],
                      bus.commit_flags[FLG_ZERO]};
    assign w_entry = {bus.commit_pc, bus.commit_instr, bus.commit_alu, w_flags};
    assign w_pop   = bus.rd_en && w_count != '0 && !bus.arm;
    always_comb begin
        w_run   = r_state == ST_ARMED || r_state == ST_CAPTURE;
        w_rep_n = bus.commit_pc == r_last_pc ? r_rep + 1'b1 : RW'(1);
        w_wr    = w_run && bus.commit_valid && !bus.arm && !bus.stop &&
                  (r_state == ST_CAPTURE || bus.commit_pc == bus.trig_pc);
        w_to    = w_run && r_cycle == CYC_W'(MAX_CYCLES - 1);
        w_halt  = r_state == ST_CAPTURE && w_wr && w_rep_n == RW'(HALT_REPEAT);
        // in first-N mode the entry that fills the last slot ends the run
        w_fill  = WRAP_MODE == 0 && w_wr && !w_pop && w_count == CW'(DEPTH - 1);
        w_next  = bus.arm ? (bus.trig_en ? ST_ARMED : ST_CAPTURE) :
                  (w_run && (bus.stop || w_to || w_halt || w_fill)) ? ST_DONE :
                  (r_state == ST_ARMED && w_wr) ? ST_CAPTURE : r_state;
    end
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (reset || bus.arm) begin
            r_halted   <= 1'b0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
            r_cycle    <= '0;
            r_last_pc  <= '0;
            r_rep      <= '0;
        end else begin
            if (w_run && w_next != ST_DONE) r_cycle <= r_cycle + 1'b1;
            if (w_to && !bus.stop) r_timeout <= 1'b1;
            if (w_halt) r_halted <= 1'b1;
            if (w_ovf) r_overflow <= 1'b1;
            if (r_state == ST_CAPTURE && w_wr) begin
                r_last_pc <= bus.commit_pc;
                r_rep     <= w_rep_n;
            end
        end
    end
    trace_ring_mem #(.DEPTH(DEPTH), .W(EW), .WRAP(WRAP_MODE)) u_mem (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (bus.arm),
        .i_wr      (w_wr),
        .i_wr_data (w_entry),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_data),
        .o_rd_valid(w_rd_valid),
        .o_count   (w_count),
        .o_ovf     (w_ovf)
    );
    assign bus.rd_data     = w_rd_data;
    assign bus.rd_valid    = w_rd_valid;
    assign bus.count       = w_count;
    assign bus.state       = r_state;
    assign bus.halted      = r_halted;
    assign bus.timeout     = r_timeout;
    assign bus.overflow    = r_overflow;
    assign bus.cycle_count = r_cycle;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed checks of first-N and last-N trace buffers driven in lockstep
module tb_cpu_trace_buffer;
    logic        clk = 1'b0, reset = 1'b1;
    logic        arm = 1'b0, stop = 1'b0, cv = 1'b0, trig_en = 1'b0, rd_en = 1'b0;
    logic [31:0] pc = '0, instr = '0, alu = '0, trig_pc = '0;
    logic [4:0]  flags = '0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer_if #(.XLEN(32), .DEPTH(16), .CYC_W(16)) b0 ();
    cpu_trace_buffer_if #(.XLEN(32), .DEPTH(16), .CYC_W(16)) b1 ();

    assign b0.arm = arm;           assign b1.arm = arm;
    assign b0.stop = stop;         assign b1.stop = stop;
    assign b0.commit_valid = cv;   assign b1.commit_valid = cv;
    assign b0.commit_pc = pc;      assign b1.commit_pc = pc;
    assign b0.commit_instr = instr; assign b1.commit_instr = instr;
    assign b0.commit_alu = alu;    assign b1.commit_alu = alu;
    assign b0.commit_flags = flags; assign b1.commit_flags = flags;
    assign b0.trig_en = trig_en;   assign b1.trig_en = trig_en;
    assign b0.trig_pc = trig_pc;   assign b1.trig_pc = trig_pc;
    assign b0.rd_en = rd_en;       assign b1.rd_en = rd_en;

    cpu_trace_buffer #(.XLEN(32), .DEPTH(16), .WRAP_MODE(0), .HALT_REPEAT(4),
                       .MAX_CYCLES(100), .CYC_W(16)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    cpu_trace_buffer #(.XLEN(32), .DEPTH(16), .WRAP_MODE(1), .HALT_REPEAT(4),
                       .MAX_CYCLES(100), .CYC_W(16)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [100:0] ent(input logic [31:0] p);
        return {p, 32'h13 ^ (p << 4), p + 32'h100, p[6:2]};
    endfunction

    task automatic commit(input logic [31:0] p);
        cv = 1'b1;
        pc = p;
        instr = 32'h13 ^ (p << 4);
        alu = p + 32'h100;
        flags = p[6:2];
        tick();
        cv = 1'b0;
    endtask

    task automatic do_arm(input logic te);
        trig_en = te;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running want=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        tick();
        tick();
        check("rst_state", b0.state, 0);
        check("rst_count", b0.count, 0);
        check("rst_rd_valid", b0.rd_valid, 0);
        check("rst_rd_data", b0.rd_data, 0);
        check("rst_flags", {b0.halted, b0.timeout, b0.overflow}, 0);
        check("rst_cycle", b0.cycle_count, 0);
        reset = 1'b0;
        tick();

        do_arm(1'b0);
        check("arm_state0", b0.state, 2);
        check("arm_state1", b1.state, 2);
        for (int i = 0; i < 20; i++) begin
            commit(32'(4 * i));
            if (i == 14) check("pre_full_state", b0.state, 2);
            if (i == 15) check("full_done", b0.state, 3);
        end
        check("first_n_count", b0.count, 16);
        check("first_n_ovf", b0.overflow, 0);
        check("last_n_count", b1.count, 16);
        check("last_n_ovf", b1.overflow, 1);
        check("last_n_state", b1.state, 2);
        for (int j = 0; j < 16; j++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            check("pop_valid", b0.rd_valid, 1);
            check("pop_first_n", b0.rd_data, ent(32'(4 * j)));
            check("pop_last_n", b1.rd_data, ent(32'h10 + 32'(4 * j)));
        end
        check("drained0", b0.count, 0);
        check("drained1", b1.count, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("empty_pop_valid", b0.rd_valid, 0);
        check("empty_pop_hold", b0.rd_data, ent(32'h3C));
        check("empty_pop_count", b0.count, 0);

        trig_pc = 32'h20;
        do_arm(1'b1);
        check("trig_armed", b0.state, 1);
        for (int i = 0; i < 16; i++) commit(32'(4 * i));
        check("trig_count", b0.count, 8);
        check("trig_state", b0.state, 2);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("trig_first", b0.rd_data, ent(32'h20));

        do_arm(1'b0);
        commit(32'h8);
        for (int i = 0; i < 3; i++) commit(32'hC);
        check("halt_not_yet", b0.halted, 0);
        check("halt_not_yet_state", b0.state, 2);
        commit(32'hC);
        check("halted", b0.halted, 1);
        check("halt_state", b0.state, 3);
        check("halt_count", b0.count, 5);
        commit(32'h40);
        check("done_blocks_write", b0.count, 5);

        do_arm(1'b0);
        for (int i = 0; i < 99; i++) tick();
        check("wd_before_state", b0.state, 2);
        check("wd_before_flag", b0.timeout, 0);
        check("wd_before_cycle", b0.cycle_count, 99);
        tick();
        check("wd_timeout", b0.timeout, 1);
        check("wd_state", b0.state, 3);
        check("wd_cycle", b0.cycle_count, 99);
        tick();
        check("wd_cycle_frozen", b0.cycle_count, 99);

        do_arm(1'b0);
        commit(32'h100);
        stop = 1'b1;
        commit(32'h104);
        stop = 1'b0;
        check("stop_state", b0.state, 3);
        check("stop_count", b0.count, 1);
        arm = 1'b1;
        rd_en = 1'b1;
        tick();
        arm = 1'b0;
        rd_en = 1'b0;
        check("arm_pop_valid", b0.rd_valid, 0);
        check("arm_pop_count", b0.count, 0);
        check("arm_pop_state", b0.state, 2);

        commit(32'h200);
        commit(32'h204);
        check("mid_count", b0.count, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_state", b0.state, 0);
        check("mid_rst_count", b0.count, 0);
        check("mid_rst_rd_data", b0.rd_data, 0);
        check("mid_rst_cycle", b0.cycle_count, 0);
        check("mid_rst_rd_valid", b0.rd_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
